// File: rtl/press_classifier_pkg.sv
// Shared state encoding and timing helpers for the button press classifier.
package press_classifier_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESSED = 3'd1,
        HELD    = 3'd2,
        GAP     = 3'd3,
        SECOND  = 3'd4
    } pc_state_t;

    // Truncating conversion; a zero result is rejected by the user at elaboration.
    function automatic int us_to_cycles(input longint us, input longint clk_per);
        longint cyc;
        cyc = 0;
        if (clk_per > 0) begin
            cyc = (us * 64'sd1000) / clk_per;
        end
        return int'(cyc);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Saturating up-counter with synchronous clear and a match flag against a
// limit that the user may change from cycle to cycle.
module interval_timer
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         match
);

    logic [W-1:0] count;

    // Holds at all-ones so a long idle stretch can never alias a short interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + W'(1);
        end
    end

    assign match = (count == limit);

endmodule

// File: rtl/press_classifier.sv
// Classifies a debounced button level into short, long, double and
// auto-repeat one-cycle pulses.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int CLK_PER   = 10,
    parameter int LONG_US   = 500000,
    parameter int DOUBLE_US = 250000,
    parameter int REPEAT_US = 100000,
    parameter bit DOUBLE_EN = 1'b1
) (
    input  logic clk,
    input  logic CPU_RESETN,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_tick,
    output logic busy
);

    localparam int LONG_CYC = us_to_cycles(longint'(LONG_US),   longint'(CLK_PER));
    localparam int DBL_CYC  = us_to_cycles(longint'(DOUBLE_US), longint'(CLK_PER));
    localparam int REP_CYC  = us_to_cycles(longint'(REPEAT_US), longint'(CLK_PER));
    localparam int MAX_CYC  = max3(LONG_CYC, DBL_CYC, REP_CYC);
    localparam int TW       = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] LONG_LIM = TW'(LONG_CYC - 1);
    localparam logic [TW-1:0] DBL_LIM  = TW'(DBL_CYC - 1);
    localparam logic [TW-1:0] REP_LIM  = TW'(REP_CYC - 1);

    generate
        if (LONG_CYC < 1 || DBL_CYC < 1 || REP_CYC < 1) begin : g_bad_timing
            $error("press_classifier: a derived cycle count evaluates to zero");
        end
    endgenerate

    pc_state_t     state;
    pc_state_t     next_state;
    logic [TW-1:0] limit;
    logic          match;
    logic          timer_clear;
    logic          short_next;
    logic          long_next;
    logic          double_next;
    logic          repeat_next;

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Releases are tested before the timer match so a release on the
    // boundary cycle wins over long/repeat, and a press wins over GAP expiry.
    always_comb begin
        next_state  = state;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        repeat_next = 1'b0;
        case (state)
            IDLE: begin
                if (btn_level) next_state = PRESSED;
            end
            PRESSED: begin
                if (!btn_level) begin
                    if (DOUBLE_EN) begin
                        next_state = GAP;
                    end else begin
                        short_next = 1'b1;
                        next_state = IDLE;
                    end
                end else if (match) begin
                    long_next  = 1'b1;
                    next_state = HELD;
                end
            end
            HELD: begin
                if (!btn_level) begin
                    next_state = IDLE;
                end else if (match) begin
                    repeat_next = 1'b1;
                end
            end
            GAP: begin
                if (btn_level) begin
                    double_next = 1'b1;
                    next_state  = SECOND;
                end else if (match) begin
                    short_next = 1'b1;
                    next_state = IDLE;
                end
            end
            SECOND: begin
                if (!btn_level) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        limit = '0;
        case (state)
            PRESSED: limit = LONG_LIM;
            HELD:    limit = REP_LIM;
            GAP:     limit = DBL_LIM;
            default: limit = '0;
        endcase
    end

    // The repeat tick restarts the interval without leaving HELD.
    assign timer_clear = (next_state != state) || repeat_next;

    interval_timer #(
        .W(TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (CPU_RESETN),
        .clear (timer_clear),
        .limit (limit),
        .match (match)
    );

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            repeat_tick  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= short_next;
            long_press   <= long_next;
            double_press <= double_next;
            repeat_tick  <= repeat_next;
            busy         <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Randomised and directed bench for press_classifier, run with double-press
// detection both enabled and disabled against a timestamp-based model.
module tb_press_classifier;

    localparam int CLK_PER   = 1000;
    localparam int LONG_US   = 20;
    localparam int DOUBLE_US = 10;
    localparam int REPEAT_US = 5;
    localparam int LONG_N    = 20;
    localparam int DBL_N     = 10;
    localparam int REP_N     = 5;

    logic clk        = 1'b0;
    logic CPU_RESETN = 1'b0;
    logic btn_level  = 1'b0;
    logic sp0, lp0, dp0, rt0, bz0;
    logic sp1, lp1, dp1, rt1, bz1;

    press_classifier #(
        .CLK_PER(CLK_PER), .LONG_US(LONG_US), .DOUBLE_US(DOUBLE_US),
        .REPEAT_US(REPEAT_US), .DOUBLE_EN(1'b1)
    ) dut (
        .clk(clk), .CPU_RESETN(CPU_RESETN), .btn_level(btn_level),
        .short_press(sp0), .long_press(lp0), .double_press(dp0),
        .repeat_tick(rt0), .busy(bz0)
    );

    press_classifier #(
        .CLK_PER(CLK_PER), .LONG_US(LONG_US), .DOUBLE_US(DOUBLE_US),
        .REPEAT_US(REPEAT_US), .DOUBLE_EN(1'b0)
    ) dut_nd (
        .clk(clk), .CPU_RESETN(CPU_RESETN), .btn_level(btn_level),
        .short_press(sp1), .long_press(lp1), .double_press(dp1),
        .repeat_tick(rt1), .busy(bz1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int cnt  [2][4];
    int last [2][4];
    int base [2][4];
    int ph   [2];
    int t0   [2];
    int ev   [2];
    bit exp_busy [2];
    bit den  [2] = '{1'b1, 1'b0};
    string iname [2] = '{"dut", "dut_nd"};
    string kname [5] = '{"short_press", "long_press", "double_press", "repeat_tick", "busy"};

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic logic [4:0] outs(input int i);
        if (i == 0) return {bz0, rt0, dp0, lp0, sp0};
        return {bz1, rt1, dp1, lp1, sp1};
    endfunction

    // Model works on sample indices: t0 is the sample that opened the
    // current phase, and events fire at fixed distances from it.
    task automatic model_step(input int i);
        ev[i] = -1;
        if (!CPU_RESETN) begin
            ph[i] = 0;
            exp_busy[i] = 1'b0;
            return;
        end
        case (ph[i])
            0: if (btn_level) begin ph[i] = 1; t0[i] = cyc; end
            1: if (!btn_level) begin
                   if (den[i]) begin ph[i] = 3; t0[i] = cyc; end
                   else begin ev[i] = 0; ph[i] = 0; end
               end else if (cyc - t0[i] == LONG_N) begin
                   ev[i] = 1; ph[i] = 2; t0[i] = cyc;
               end
            2: if (!btn_level) ph[i] = 0;
               else if ((cyc - t0[i]) % REP_N == 0) ev[i] = 3;
            3: if (btn_level) begin ev[i] = 2; ph[i] = 4; end
               else if (cyc - t0[i] == DBL_N) begin ev[i] = 0; ph[i] = 0; end
            4: if (!btn_level) ph[i] = 0;
            default: ph[i] = 0;
        endcase
        exp_busy[i] = (ph[i] != 0);
    endtask

    initial begin : compare
        logic [4:0] o;
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) model_step(i);
            #1;
            for (int i = 0; i < 2; i++) begin
                o = outs(i);
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("%s.%s@%0d", iname[i], kname[k], cyc),
                          int'(o[k]), int'(ev[i] == k));
                    if (o[k]) begin
                        cnt[i][k]++;
                        last[i][k] = cyc;
                    end
                end
                check($sformatf("%s.busy@%0d", iname[i], cyc), int'(o[4]), int'(exp_busy[i]));
            end
        end
    end

    // Must be called at a negedge; each iteration yields one sample of v.
    task automatic apply_stimulus(input logic v, input int n);
        repeat (n) begin
            btn_level = v;
            @(negedge clk);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) base[i][k] = cnt[i][k];
    endtask

    function automatic int delta(input int i, input int k);
        return cnt[i][k] - base[i][k];
    endfunction

    task automatic check_output(input string name, input int i, input int expected);
        check(name, int'(outs(i)), expected);
    endtask

    initial begin : stimulus
        int s;
        int r;
        int p;
        repeat (3) @(negedge clk);
        check_output("reset.dut", 0, 0);
        check_output("reset.dut_nd", 1, 0);
        CPU_RESETN = 1'b1;
        apply_stimulus(1'b0, 3);

        snap();
        apply_stimulus(1'b1, 5);
        r = cyc + 1;
        apply_stimulus(1'b0, 15);
        check("A.short_count", delta(0, 0), 1);
        check("A.short_latency", last[0][0] - r, DBL_N);
        check("A.other_pulses", delta(0, 1) + delta(0, 2) + delta(0, 3), 0);
        check("A.nd_short_latency", last[1][0] - r, 0);

        snap();
        s = cyc + 1;
        apply_stimulus(1'b1, 32);
        apply_stimulus(1'b0, 12);
        check("B.long_count", delta(0, 1), 1);
        check("B.long_latency", last[0][1] - s, 20);
        check("B.repeat_count", delta(0, 3), 2);
        check("B.last_repeat", last[0][3] - s, 30);
        check("B.no_short", delta(0, 0), 0);
        check("B.nd_long_latency", last[1][1] - s, 20);

        snap();
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 4);
        p = cyc + 1;
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 15);
        check("C.double_count", delta(0, 2), 1);
        check("C.double_latency", last[0][2] - p, 0);
        check("C.no_short", delta(0, 0), 0);
        check("C.nd_short_count", delta(1, 0), 2);

        snap();
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 10);
        p = cyc + 1;
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 15);
        check("D.boundary_double", delta(0, 2), 1);
        check("D.double_latency", last[0][2] - p, 0);

        snap();
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 11);
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 15);
        check("D.late_short_count", delta(0, 0), 2);
        check("D.late_no_double", delta(0, 2), 0);

        snap();
        apply_stimulus(1'b1, 20);
        r = cyc + 1;
        apply_stimulus(1'b0, 15);
        check("E.release_wins_short", delta(0, 0), 1);
        check("E.release_wins_no_long", delta(0, 1), 0);
        check("E.short_latency", last[0][0] - r, DBL_N);
        check("E.nd_short_latency", last[1][0] - r, 0);
        snap();
        apply_stimulus(1'b1, 21);
        apply_stimulus(1'b0, 5);
        check("E.long_after_21", delta(0, 1), 1);

        apply_stimulus(1'b0, 3);
        apply_stimulus(1'b1, 27);
        @(posedge clk);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check_output("F.dut_async_reset", 0, 0);
        check_output("F.nd_async_reset", 1, 0);
        snap();
        repeat (3) @(negedge clk);
        CPU_RESETN = 1'b1;
        s = cyc + 1;
        apply_stimulus(1'b1, 25);
        check("F.long_after_reset", delta(0, 1), 1);
        check("F.long_latency", last[0][1] - s, 20);
        apply_stimulus(1'b0, 12);

        repeat (40) begin
            apply_stimulus(1'b1, int'($urandom_range(1, 28)));
            apply_stimulus(1'b0, int'($urandom_range(1, 13)));
        end
        apply_stimulus(1'b0, 30);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
